// File: rtl/serial_pattern_gen_moore_if.sv
// Serial pattern generator bus: frame programming in, serial stream out.
// The master side programs frames and the slave side emits the bitstream.
interface serial_pattern_gen_moore_if #(
  parameter int W  = 32,
  parameter int CW = 6
);
  logic          load;
  logic [W-1:0]  data;
  logic [CW-1:0] len;
  logic          start;
  logic          repeat_en;
  logic          x;
  logic          x_valid;
  logic          busy;
  logic          done;
  logic [CW-1:0] match_cnt;
  logic [1:0]    Q;

  modport master (
    output load, data, len, start, repeat_en,
    input  x, x_valid, busy, done, match_cnt, Q
  );

  modport slave (
    input  load, data, len, start, repeat_en,
    output x, x_valid, busy, done, match_cnt, Q
  );
endinterface

// File: rtl/serial_pattern_gen_moore.sv
// Moore serial pattern generator: shifts a programmable-length word out
// MSB-first and keeps an overlapping "101" reference count per frame.
module serial_pattern_gen_moore #(
  parameter int W  = 32,
  parameter int CW = 6
) (
  input logic                     clk,
  input logic                     clear_n,
  serial_pattern_gen_moore_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SHIFT = 2'b01;
  localparam logic [1:0] DONE  = 2'b10;

  logic [1:0]    state;
  logic [W-1:0]  shift_reg;
  logic [W-1:0]  sh_data;
  logic [CW-1:0] sh_len;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] cnt;
  logic [1:0]    hist;

  logic [W-1:0]  fr_data;
  logic [CW-1:0] fr_len;
  logic [CW-1:0] len_eff;
  logic [W-1:0]  aligned;
  logic          go;
  logic          cur;
  logic          hit;

  // A same-cycle load feeds the frame start directly.
  always_comb begin
    fr_data = bus.load ? bus.data : sh_data;
    fr_len  = bus.load ? bus.len  : sh_len;
    len_eff = fr_len;
    if (fr_len == '0 || fr_len > CW'(W))
      len_eff = CW'(W);
    aligned = fr_data << (W - int'(len_eff));
    go  = (state == IDLE && bus.start) ||
          (state == DONE && bus.repeat_en);
    cur = shift_reg[W-1];
    hit = (hist == 2'b10) && cur;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      sh_data   <= '0;
      sh_len    <= '0;
      bit_cnt   <= '0;
      cnt       <= '0;
      hist      <= '0;
    end else begin
      if (bus.load) begin
        sh_data <= bus.data;
        sh_len  <= bus.len;
      end
      if (go) begin
        shift_reg <= aligned;
        bit_cnt   <= len_eff;
        cnt       <= '0;
        hist      <= '0;
        state     <= SHIFT;
      end else begin
        unique case (state)
          SHIFT: begin
            shift_reg <= shift_reg << 1;
            bit_cnt   <= bit_cnt - CW'(1);
            hist      <= {hist[0], cur};
            if (hit && cnt != '1)
              cnt <= cnt + CW'(1);
            if (bit_cnt == CW'(1))
              state <= DONE;
          end
          DONE:    state <= IDLE;
          IDLE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.x         = (state == SHIFT) & shift_reg[W-1];
  assign bus.x_valid   = (state == SHIFT);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.match_cnt = cnt;
  assign bus.Q         = state;
endmodule

// File: tb/tb_serial_pattern_gen_moore.sv
// Directed bench for serial_pattern_gen_moore with hand-computed frames.
// Inputs change and outputs are sampled on the falling edge.
module tb_serial_pattern_gen_moore;
  logic clk;
  logic clear_n;
  int   n_cmp;
  int   n_err;

  serial_pattern_gen_moore_if #(.W(32), .CW(6)) bus ();

  serial_pattern_gen_moore #(.W(32), .CW(6)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic capture(
    input  int          n,
    output logic [31:0] bits,
    output int          nv,
    output logic        dn,
    output logic        dv,
    output logic [5:0]  cn
  );
    bits = '0;
    nv   = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.start = 1'b0;
        bus.load  = 1'b0;
      end
      bits = {bits[30:0], bus.x};
      nv   = nv + int'(bus.x_valid);
    end
    @(negedge clk);
    dn = bus.done;
    dv = bus.x_valid;
    cn = bus.match_cnt;
  endtask

  task automatic test_reset();
    logic [31:0] b;
    int nv;
    logic dn, dv;
    logic [5:0] cn;
    clear_n   = 1'b0;
    bus.start = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.x, bus.x_valid, bus.busy, bus.done} !== 4'b0) begin
      n_err++;
      $display("FAIL rst_outs: got %b want 0000",
               {bus.x, bus.x_valid, bus.busy, bus.done});
    end
    n_cmp++;
    if (bus.Q !== 2'b00) begin
      n_err++;
      $display("FAIL rst_q: got %b want 00", bus.Q);
    end
    n_cmp++;
    if (bus.match_cnt !== 6'd0) begin
      n_err++;
      $display("FAIL rst_cnt: got %0d want 0", bus.match_cnt);
    end
    clear_n = 1'b1;
    capture(32, b, nv, dn, dv, cn);
    n_cmp++;
    if (b !== 32'h0 || nv !== 32) begin
      n_err++;
      $display("FAIL rst_frame: got %h/%0d want 0/32", b, nv);
    end
    n_cmp++;
    if (dn !== 1'b1 || cn !== 6'd0) begin
      n_err++;
      $display("FAIL rst_done: got %b/%0d want 1/0", dn, cn);
    end
  endtask

  task automatic test_full_word();
    logic [31:0] b;
    int nv;
    logic dn, dv;
    logic [5:0] cn;
    bus.load = 1'b1;
    bus.data = 32'hCD4C9ACA;
    bus.len  = 6'd0;
    @(negedge clk);
    bus.load  = 1'b0;
    bus.start = 1'b1;
    capture(32, b, nv, dn, dv, cn);
    n_cmp++;
    if (b !== 32'hCD4C9ACA || nv !== 32) begin
      n_err++;
      $display("FAIL full_bits: got %h/%0d want cd4c9aca/32", b, nv);
    end
    n_cmp++;
    if (dn !== 1'b1 || dv !== 1'b0 || cn !== 6'd5) begin
      n_err++;
      $display("FAIL full_done: got %b%b/%0d want 10/5", dn, dv, cn);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.Q !== 2'b00 || bus.done !== 1'b0 || bus.match_cnt !== 6'd5) begin
      n_err++;
      $display("FAIL full_hold: got %b%b/%0d want 000/5",
               bus.Q, bus.done, bus.match_cnt);
    end
  endtask

  task automatic test_short_frame();
    logic [31:0] b;
    int nv;
    logic dn, dv;
    logic [5:0] cn;
    bus.load  = 1'b1;
    bus.start = 1'b1;
    bus.data  = 32'h5;
    bus.len   = 6'd3;
    capture(3, b, nv, dn, dv, cn);
    n_cmp++;
    if (b !== 32'h5 || nv !== 3) begin
      n_err++;
      $display("FAIL short_bits: got %h/%0d want 5/3", b, nv);
    end
    n_cmp++;
    if (dn !== 1'b1 || dv !== 1'b0 || cn !== 6'd1) begin
      n_err++;
      $display("FAIL short_done: got %b%b/%0d want 10/1", dn, dv, cn);
    end
  endtask

  task automatic test_repeat();
    logic [31:0] b;
    int nv;
    logic dn, dv;
    logic [5:0] cn;
    @(negedge clk);
    bus.repeat_en = 1'b1;
    bus.load      = 1'b1;
    bus.start     = 1'b1;
    bus.data      = 32'h5;
    bus.len       = 6'd3;
    for (int f = 0; f < 3; f++) begin
      capture(3, b, nv, dn, dv, cn);
      n_cmp++;
      if (b !== 32'h5 || nv !== 3 || dn !== 1'b1 ||
          dv !== 1'b0 || cn !== 6'd1) begin
        n_err++;
        $display("FAIL rep_frame%0d: got %h/%0d/%b%b/%0d want 5/3/10/1",
                 f, b, nv, dn, dv, cn);
      end
    end
    bus.repeat_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.Q !== 2'b00 || bus.x_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rep_stop: got %b%b want 000", bus.Q, bus.x_valid);
    end
  endtask

  task automatic test_ignored();
    logic [31:0] b;
    int nv;
    logic dn, dv;
    logic [5:0] cn;
    bus.load  = 1'b1;
    bus.start = 1'b1;
    bus.data  = 32'hCD4C9ACA;
    bus.len   = 6'd0;
    b = '0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i == 5) begin
        bus.start = 1'b1;
        bus.load  = 1'b1;
        bus.data  = 32'hF;
        bus.len   = 6'd4;
      end else begin
        bus.start = 1'b0;
        bus.load  = 1'b0;
      end
      b = {b[30:0], bus.x};
    end
    @(negedge clk);
    n_cmp++;
    if (b !== 32'hCD4C9ACA) begin
      n_err++;
      $display("FAIL ign_bits: got %h want cd4c9aca", b);
    end
    n_cmp++;
    if (bus.done !== 1'b1 || bus.match_cnt !== 6'd5) begin
      n_err++;
      $display("FAIL ign_done: got %b/%0d want 1/5",
               bus.done, bus.match_cnt);
    end
    @(negedge clk);
    bus.start = 1'b1;
    capture(4, b, nv, dn, dv, cn);
    n_cmp++;
    if (b !== 32'hF || nv !== 4) begin
      n_err++;
      $display("FAIL defer_bits: got %h/%0d want f/4", b, nv);
    end
    n_cmp++;
    if (dn !== 1'b1 || cn !== 6'd0) begin
      n_err++;
      $display("FAIL defer_done: got %b/%0d want 1/0", dn, cn);
    end
  endtask

  task automatic test_reset_midframe();
    int dn_seen;
    @(negedge clk);
    bus.load  = 1'b1;
    bus.start = 1'b1;
    bus.data  = 32'hAAAAAAAA;
    bus.len   = 6'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.load  = 1'b0;
      bus.start = 1'b0;
    end
    n_cmp++;
    if (bus.x_valid !== 1'b1 || bus.match_cnt !== 6'd4) begin
      n_err++;
      $display("FAIL mid_pre: got %b/%0d want 1/4",
               bus.x_valid, bus.match_cnt);
    end
    #2 clear_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.x, bus.x_valid, bus.busy} !== 3'b0 || bus.Q !== 2'b00) begin
      n_err++;
      $display("FAIL mid_async: got %b/%b want 000/00",
               {bus.x, bus.x_valid, bus.busy}, bus.Q);
    end
    n_cmp++;
    if (bus.match_cnt !== 6'd0) begin
      n_err++;
      $display("FAIL mid_cnt: got %0d want 0", bus.match_cnt);
    end
    dn_seen = 0;
    repeat (2) begin
      @(negedge clk);
      dn_seen = dn_seen + int'(bus.done);
    end
    clear_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      dn_seen = dn_seen + int'(bus.done) + int'(bus.busy);
    end
    n_cmp++;
    if (dn_seen !== 0) begin
      n_err++;
      $display("FAIL mid_nodone: got %0d want 0", dn_seen);
    end
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    bus.load      = 1'b0;
    bus.data      = '0;
    bus.len       = '0;
    bus.start     = 1'b0;
    bus.repeat_en = 1'b0;
    test_reset();
    test_full_word();
    test_short_frame();
    test_repeat();
    test_ignored();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
